primitive_assembler: RTL and testbench
======================================

# primitive_assembler

Consumes the vertex/primitive control stream produced by the instruction decode stage: SETVERTEX, STARTPRIMITIVE, ENDPRIMITIVE and DRAW. It groups incoming vertices into points, lines or triangles according to the active primitive type. Assembled primitives and frame markers are queued in an order-preserving FIFO and sent to the rasterizer over a valid/ready handshake. Backpressure to the decode stage is a single Stall line.

## Interface
- FIFO_DEPTH, 4, number of queued output entries (power of two, ≥2)
- PTR_WIDTH, 2, log2(FIFO_DEPTH)
- CLK  in  1  clock; all state updates on posedge
- RESET_N  in  1  asynchronous, active-low reset
- VertexValid  in  1  Vertex carries a SETVERTEX value this cycle
- Vertex  in  32  X=[15:0], Y=[31:16]
- StartPrimitive  in  1  begin primitive of PrimitiveType
- PrimitiveType  in  4  0 POINTS, 1 LINES, 2 LINE_STRIP, 3 TRIANGLES, 4 TRI_STRIP, 5 TRI_FAN
- EndPrimitive  in  1  close current primitive
- Draw  in  1  frame flush request
- Stall  out  1  FIFO full; decode must hold its instruction
- OutValid  out  1  head entry valid
- OutReady  in  1  rasterizer accepts head
- OutType  out  4  primitive type of head; 4'hF = DRAW marker
- OutV0, OutV1, OutV2  out  32 each  head vertices; unused slots are 0
- ProtoErr  out  1  one-cycle pulse on protocol violation
- PrimCount  out  16  primitives emitted since last DRAW (see Configuration)

## Operation
- States: IDLE, COLLECT. The decoder emits one instruction per cycle.
- Input priority when several strobes are high: StartPrimitive > VertexValid > EndPrimitive > Draw. Lower-priority strobes are dropped and raise ProtoErr.
- All inputs are ignored while Stall=1.
- StartPrimitive
  - Latches the type, clears the vertex count, and enters COLLECT.
  - Types 6–15: stay in or enter IDLE, ProtoErr.
  - In COLLECT with an incomplete group: the partial group is discarded, ProtoErr, then the new primitive starts.
- VertexValid in COLLECT
  - Stores the vertex in history regs A (first), B (previous), C (current).
  - Increments vtx count, saturating at 3; a separate parity bit tracks odd/even.
- VertexValid in IDLE: dropped, ProtoErr.
- Emission rules (n = 0-based vertex index within the primitive):
  - POINTS: every vertex → (v).
  - LINES: odd n → (v[n-1], v[n]).
  - LINE_STRIP: n≥1 → (v[n-1], v[n]).
  - TRIANGLES: n%3==2 → (v[n-2], v[n-1], v[n]).
  - TRI_STRIP: n≥2, even n → (v[n-2], v[n-1], v[n]); odd n → (v[n-1], v[n-2], v[n]), preserving winding.
  - TRI_FAN: n≥2 → (v[0], v[n-1], v[n]).
- EndPrimitive
  - In COLLECT: return to IDLE. Leftover incomplete group (LINES odd count, TRIANGLES count%3≠0) → ProtoErr.
  - In IDLE: ProtoErr.
- Draw: accepted in either state and pushes a marker entry (type F, vertices 0). State is unchanged.

## Timing
- Accepted input at edge N → entry written at edge N → OutValid=1 during cycle N+1 when the FIFO was empty. Latency is 1 cycle.
- Head transfer occurs on a posedge with OutValid & OutReady.
- Stall = (count == FIFO_DEPTH), combinational from registered count.
  - When full, no write happens even if a read occurs in the same cycle.
  - Stall drops the cycle after a pop.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance, wrapping modulo FIFO_DEPTH.
- OutV*/OutType must stay stable while OutValid & !OutReady.
- Reset (asynchronous, any time, including mid-primitive or with the FIFO non-empty):
  - Clears state to IDLE, pointers, count, history, FIFO memory and PrimCount.
  - Outputs: Stall=0, OutValid=0, OutType=0, OutV*=0, ProtoErr=0, PrimCount=0.

## Configuration
- PRIM_STATS_EN defined:
  - PrimCount increments on each primitive push and saturates at 16'hFFFF.
  - A DRAW marker push resets it to 0.
- PRIM_STATS_EN undefined: PrimCount is constant 0 and the counter logic is absent.

## Structure
- Shared package gpu_prim_pkg holds:
  - primitive type codes PT_POINTS..PT_TRI_FAN
  - PT_DRAW_MARKER = 4'hF
  - entry width constant (4+96)
- Sub-module prim_fifo is a parameterised synchronous FIFO with full/empty/count, cleared on RESET_N.
- The FSM, history registers and emission logic live in primitive_assembler.

## Test plan
- TRIANGLES, vertices 0x00010001, 0x00020002, 0x00030003, OutReady=1 → one entry, type 3, V0..V2 in that order, OutValid 1 cycle after the third vertex.
- TRI_STRIP with 4 vertices a, b, c, d → entries (a,b,c) then (c,b,d). TRI_FAN with a, b, c, d → (a,b,c), (a,c,d).
- OutReady=0 with FIFO_DEPTH=4 and POINTS ×5 → Stall=1 after the 4th; the 5th is held. One pop → Stall=0 next cycle, 5th accepted, ordering intact.
- LINES with 3 vertices, then EndPrimitive → one line, ProtoErr pulse on EndPrimitive; Vertex in IDLE → ProtoErr, no entry.
- Draw after 2 lines → marker entry type F follows both lines. With PRIM_STATS_EN, PrimCount = 2 before the marker and 0 after.
- RESET_N low mid-TRIANGLES with 2 entries queued → OutValid=0, Stall=0 immediately; after release, a new primitive assembles from an empty history.

Source files
------------

// File: rtl/gpu_prim_pkg.sv
// Shared primitive-assembly types: primitive codes, FIFO entry layout
// and assembler FSM states.
package gpu_prim_pkg;

    localparam logic [3:0] PT_POINTS      = 4'd0;
    localparam logic [3:0] PT_LINES       = 4'd1;
    localparam logic [3:0] PT_LINE_STRIP  = 4'd2;
    localparam logic [3:0] PT_TRIANGLES   = 4'd3;
    localparam logic [3:0] PT_TRI_STRIP   = 4'd4;
    localparam logic [3:0] PT_TRI_FAN     = 4'd5;
    localparam logic [3:0] PT_DRAW_MARKER = 4'hF;

    localparam int ENTRY_W = 4 + 96;

    typedef struct packed {
        logic [3:0]  ptype;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } prim_entry_t;

    typedef enum logic {
        IDLE,
        COLLECT
    } pa_state_e;

endpackage

// File: rtl/prim_fifo.sv
// Order-preserving synchronous FIFO with full/empty/count flags.
// Memory and pointers are cleared on reset; head reads as 0 when empty.
module prim_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 100
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign do_push   = wr_en_i && !full_o;
    assign do_pop    = rd_en_i && !empty_o;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/primitive_assembler.sv
// Groups decoded vertices into points/lines/triangles and queues them.
// Define PRIM_STATS_EN to enable the PrimCount statistics counter.
module primitive_assembler
    import gpu_prim_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        VertexValid,
    input  logic [31:0] Vertex,
    input  logic        StartPrimitive,
    input  logic [3:0]  PrimitiveType,
    input  logic        EndPrimitive,
    input  logic        Draw,
    output logic        Stall,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [3:0]  OutType,
    output logic [31:0] OutV0,
    output logic [31:0] OutV1,
    output logic [31:0] OutV2,
    output logic        ProtoErr,
    output logic [15:0] PrimCount
);

    localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH);

    pa_state_e   state_q, state_d;
    logic [3:0]  type_q, type_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        par_q, par_d;
    logic [1:0]  m3_q, m3_d;
    logic [31:0] va_q, va_d;
    logic [31:0] vb_q, vb_d;
    logic [31:0] vc_q, vc_d;
    logic        err_q, err_d;

    logic        push_prim;
    logic        push_draw;
    logic        hit;
    logic        in_collect;
    logic        incomplete;
    prim_entry_t prim_ent;
    prim_entry_t wr_ent;
    prim_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [PTR_WIDTH:0] fifo_cnt;

    assign in_collect = (state_q == COLLECT);
    assign incomplete = (type_q == PT_LINES && par_q) ||
                        (type_q == PT_TRIANGLES && m3_q != 2'd0);

    // Emission candidate for the incoming vertex; C=v[n-1], B=v[n-2], A=v[0]
    always_comb begin
        hit            = 1'b0;
        prim_ent       = '0;
        prim_ent.ptype = type_q;
        unique case (type_q)
            PT_POINTS: begin
                hit         = 1'b1;
                prim_ent.v0 = Vertex;
            end
            PT_LINES, PT_LINE_STRIP: begin
                hit         = (type_q == PT_LINES) ? par_q : (cnt_q != 2'd0);
                prim_ent.v0 = vc_q;
                prim_ent.v1 = Vertex;
            end
            PT_TRIANGLES: begin
                hit         = (m3_q == 2'd2);
                prim_ent.v0 = vb_q;
                prim_ent.v1 = vc_q;
                prim_ent.v2 = Vertex;
            end
            PT_TRI_STRIP: begin
                hit         = (cnt_q >= 2'd2);
                prim_ent.v0 = par_q ? vc_q : vb_q;
                prim_ent.v1 = par_q ? vb_q : vc_q;
                prim_ent.v2 = Vertex;
            end
            PT_TRI_FAN: begin
                hit         = (cnt_q >= 2'd2);
                prim_ent.v0 = va_q;
                prim_ent.v1 = vc_q;
                prim_ent.v2 = Vertex;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        m3_d      = m3_q;
        va_d      = va_q;
        vb_d      = vb_q;
        vc_d      = vc_q;
        err_d     = 1'b0;
        push_prim = 1'b0;
        push_draw = 1'b0;
        if (!fifo_full) begin
            priority case (1'b1)
                StartPrimitive: begin
                    err_d = VertexValid | EndPrimitive | Draw |
                            (in_collect & incomplete);
                    cnt_d = 2'd0;
                    par_d = 1'b0;
                    m3_d  = 2'd0;
                    if (PrimitiveType <= PT_TRI_FAN) begin
                        type_d  = PrimitiveType;
                        state_d = COLLECT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                VertexValid: begin
                    err_d = EndPrimitive | Draw | !in_collect;
                    if (in_collect) begin
                        va_d      = (cnt_q == 2'd0) ? Vertex : va_q;
                        vb_d      = vc_q;
                        vc_d      = Vertex;
                        cnt_d     = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
                        par_d     = ~par_q;
                        m3_d      = (m3_q == 2'd2) ? 2'd0 : m3_q + 2'd1;
                        push_prim = hit;
                    end
                end
                EndPrimitive: begin
                    err_d   = Draw | !in_collect | (in_collect & incomplete);
                    state_d = IDLE;
                end
                Draw: begin
                    push_draw = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ent = prim_ent;
        if (push_draw) begin
            wr_ent       = '0;
            wr_ent.ptype = PT_DRAW_MARKER;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            type_q  <= PT_POINTS;
            cnt_q   <= 2'd0;
            par_q   <= 1'b0;
            m3_q    <= 2'd0;
            va_q    <= '0;
            vb_q    <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            m3_q    <= m3_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
        end
    end

    prim_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_WIDTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_ni    (RESET_N),
        .wr_en_i   (push_prim | push_draw),
        .wr_data_i (wr_ent),
        .rd_en_i   (OutReady),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    assign Stall    = (fifo_cnt == FULL_CNT);
    assign OutValid = !fifo_empty;
    assign OutType  = head.ptype;
    assign OutV0    = head.v0;
    assign OutV1    = head.v1;
    assign OutV2    = head.v2;
    assign ProtoErr = err_q;

`ifdef PRIM_STATS_EN
    logic [15:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (push_draw) begin
            pc_d = '0;
        end else if (push_prim && pc_q != 16'hFFFF) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PrimCount = pc_q;
`else
    assign PrimCount = 16'd0;
`endif

endmodule

// File: tb/tb_primitive_assembler.sv
// Directed-vector bench for primitive_assembler (FIFO_DEPTH=4).
// Expected PrimCount follows PRIM_STATS_EN when that macro is defined.
module tb_primitive_assembler;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        VertexValid = 1'b0;
    logic [31:0] Vertex = '0;
    logic        StartPrimitive = 1'b0;
    logic [3:0]  PrimitiveType = '0;
    logic        EndPrimitive = 1'b0;
    logic        Draw = 1'b0;
    logic        Stall;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [3:0]  OutType;
    logic [31:0] OutV0, OutV1, OutV2;
    logic        ProtoErr;
    logic [15:0] PrimCount;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PRIM_STATS_EN
    localparam logic [15:0] PC_TWO = 16'd2;
`else
    localparam logic [15:0] PC_TWO = 16'd0;
`endif

    primitive_assembler #(
        .FIFO_DEPTH (4),
        .PTR_WIDTH  (2)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .VertexValid    (VertexValid),
        .Vertex         (Vertex),
        .StartPrimitive (StartPrimitive),
        .PrimitiveType  (PrimitiveType),
        .EndPrimitive   (EndPrimitive),
        .Draw           (Draw),
        .Stall          (Stall),
        .OutValid       (OutValid),
        .OutReady       (OutReady),
        .OutType        (OutType),
        .OutV0          (OutV0),
        .OutV1          (OutV1),
        .OutV2          (OutV2),
        .ProtoErr       (ProtoErr),
        .PrimCount      (PrimCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [3:0] t);
        StartPrimitive = 1'b1;
        PrimitiveType  = t;
        tick();
        StartPrimitive = 1'b0;
    endtask

    task automatic vtx(input logic [31:0] v);
        VertexValid = 1'b1;
        Vertex      = v;
        tick();
        VertexValid = 1'b0;
    endtask

    task automatic endp();
        EndPrimitive = 1'b1;
        tick();
        EndPrimitive = 1'b0;
    endtask

    task automatic draw();
        Draw = 1'b1;
        tick();
        Draw = 1'b0;
    endtask

    task automatic pop();
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
    endtask

    task automatic head(input string tag, input logic [3:0] t,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        check({tag, ".valid"}, 32'(OutValid), 32'd1);
        check({tag, ".type"}, 32'(OutType), 32'(t));
        check({tag, ".v0"}, OutV0, a);
        check({tag, ".v1"}, OutV1, b);
        check({tag, ".v2"}, OutV2, c);
    endtask

    localparam logic [31:0] VA = 32'h000A000A;
    localparam logic [31:0] VB = 32'h000B000B;
    localparam logic [31:0] VC = 32'h000C000C;
    localparam logic [31:0] VD = 32'h000D000D;

    initial begin
        tick();
        check("rst.valid", 32'(OutValid), 32'd0);
        check("rst.stall", 32'(Stall), 32'd0);
        check("rst.type", 32'(OutType), 32'd0);
        check("rst.v0", OutV0, 32'd0);
        check("rst.err", 32'(ProtoErr), 32'd0);
        check("rst.pc", 32'(PrimCount), 32'd0);
        RESET_N = 1'b1;
        tick();

        // TRIANGLES with OutReady held high
        OutReady = 1'b1;
        start(4'd3);
        vtx(32'h00010001);
        vtx(32'h00020002);
        check("tri.early", 32'(OutValid), 32'd0);
        vtx(32'h00030003);
        head("tri", 4'd3, 32'h00010001, 32'h00020002, 32'h00030003);
        endp();
        check("tri.drained", 32'(OutValid), 32'd0);
        check("tri.err", 32'(ProtoErr), 32'd0);
        OutReady = 1'b0;

        // TRI_STRIP winding
        start(4'd4);
        vtx(VA); vtx(VB); vtx(VC); vtx(VD);
        endp();
        check("strip.err", 32'(ProtoErr), 32'd0);
        head("strip0", 4'd4, VA, VB, VC);
        pop();
        head("strip1", 4'd4, VC, VB, VD);
        pop();
        check("strip.empty", 32'(OutValid), 32'd0);

        // TRI_FAN
        start(4'd5);
        vtx(VA); vtx(VB); vtx(VC); vtx(VD);
        endp();
        head("fan0", 4'd5, VA, VB, VC);
        pop();
        head("fan1", 4'd5, VA, VC, VD);
        pop();

        // POINTS x5 with backpressure
        start(4'd0);
        vtx(32'd1); vtx(32'd2); vtx(32'd3);
        check("bp.stall3", 32'(Stall), 32'd0);
        vtx(32'd4);
        check("bp.stall4", 32'(Stall), 32'd1);
        VertexValid = 1'b1;
        Vertex      = 32'd5;
        tick();
        check("bp.held", 32'(Stall), 32'd1);
        head("bp.h1", 4'd0, 32'd1, 32'd0, 32'd0);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("bp.release", 32'(Stall), 32'd0);
        head("bp.h2", 4'd0, 32'd2, 32'd0, 32'd0);
        tick();
        VertexValid = 1'b0;
        check("bp.refull", 32'(Stall), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            head($sformatf("bp.d%0d", i), 4'd0, 32'(i), 32'd0, 32'd0);
            pop();
        end
        check("bp.empty", 32'(OutValid), 32'd0);
        endp();

        // LINES leftover and vertex in IDLE
        start(4'd1);
        vtx(VA); vtx(VB);
        vtx(VC);
        check("lines.noerr", 32'(ProtoErr), 32'd0);
        endp();
        check("lines.err", 32'(ProtoErr), 32'd1);
        tick();
        check("lines.pulse", 32'(ProtoErr), 32'd0);
        head("lines", 4'd1, VA, VB, 32'd0);
        pop();
        check("lines.one", 32'(OutValid), 32'd0);
        vtx(VD);
        check("idle.vtx.err", 32'(ProtoErr), 32'd1);
        check("idle.vtx.none", 32'(OutValid), 32'd0);

        // Bad type and dropped lower-priority strobe
        start(4'd7);
        check("badtype.err", 32'(ProtoErr), 32'd1);
        VertexValid = 1'b1;
        Draw        = 1'b1;
        tick();
        VertexValid = 1'b0;
        Draw        = 1'b0;
        check("multi.err", 32'(ProtoErr), 32'd1);
        check("multi.none", 32'(OutValid), 32'd0);

        // Draw marker ordering and PrimCount
        draw();
        head("draw0", 4'hF, 32'd0, 32'd0, 32'd0);
        check("draw0.pc", 32'(PrimCount), 32'd0);
        pop();
        start(4'd1);
        vtx(VA); vtx(VB); vtx(VC); vtx(VD);
        endp();
        check("draw.pc2", 32'(PrimCount), 32'(PC_TWO));
        draw();
        check("draw.pc0", 32'(PrimCount), 32'd0);
        head("draw.l0", 4'd1, VA, VB, 32'd0);
        pop();
        head("draw.l1", 4'd1, VC, VD, 32'd0);
        pop();
        head("draw.mk", 4'hF, 32'd0, 32'd0, 32'd0);
        pop();

        // Asynchronous reset mid-primitive with queued entries
        start(4'd0);
        vtx(VA); vtx(VB);
        start(4'd3);
        vtx(VC);
        check("ar.pre", 32'(OutValid), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("ar.valid", 32'(OutValid), 32'd0);
        check("ar.stall", 32'(Stall), 32'd0);
        check("ar.type", 32'(OutType), 32'd0);
        check("ar.v0", OutV0, 32'd0);
        check("ar.pc", 32'(PrimCount), 32'd0);
        tick();
        RESET_N = 1'b1;
        tick();
        start(4'd3);
        vtx(32'h11);
        vtx(32'h22);
        check("ar.partial", 32'(OutValid), 32'd0);
        vtx(32'h33);
        head("ar.tri", 4'd3, 32'h11, 32'h22, 32'h33);
        pop();
        check("ar.empty", 32'(OutValid), 32'd0);
        endp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
